// File: rtl/code_loader.sv
// code_loader
// Streams a program image from a byte-wide host link into code_storage.
// The image starts with a 16-bit little-endian line count. After that come
// the words, each made of BYTES little-endian bytes, where
// BYTES = ceil(code_size/8). Each complete word produces a one-cycle write
// strobe. Lines are written in order, starting at line 0.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start               one-cycle load request (ignored while a load runs)
//   in_data/in_valid    byte stream from the host
//   in_ready            loader accepts a byte this cycle
//   is_write            one-cycle write strobe to code_storage
//   write_line          target line for the strobe (held between strobes)
//   write_data          word for the strobe (held between strobes)
//   busy                load in progress
//   done                image fully written
//   error               line count exceeded storage capacity
module code_loader #(
  parameter int code_size     = 12,
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int BYTES = (code_size + 7) / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BUF_W = BYTES * 8;
  localparam int CAP   = max_code_line + 1;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, FINISH, DONE, ERROR
  } state_t;

  state_t             state;
  logic [7:0]         len_lo;
  logic [15:0]        len;
  logic [15:0]        word_cnt;
  logic [IDX_W-1:0]   byte_idx;
  logic [BUF_W-1:0]   word_buf;
  logic [BUF_W-1:0]   next_buf;
  logic [15:0]        len_new;
  logic               accept;
  logic               last_byte;

  assign in_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign busy      = in_ready || (state == FINISH);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
  assign len_new   = {in_data, len_lo};

  // Word buffer with the incoming byte dropped into its slot. When the last
  // byte of a word arrives, this value is the word that gets written.
  always_comb begin
    next_buf = word_buf;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) next_buf[i*8 +: 8] = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      is_write   <= 1'b0;
      write_line <= '0;
      write_data <= '0;
    end else begin
      is_write <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN_LO;
            word_cnt <= '0;
            byte_idx <= '0;
            word_buf <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= len_new;
            if (len_new == 16'd0)                   state <= DONE;
            else if (32'(len_new) > 32'(CAP))       state <= ERROR;
            else                                    state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            word_buf <= next_buf;
            if (last_byte) begin
              byte_idx   <= '0;
              is_write   <= 1'b1;
              write_line <= {16'd0, word_cnt};
              // Bits above code_size in the top byte are dropped here.
              write_data <= next_buf[code_size-1:0];
              word_cnt   <= word_cnt + 16'd1;
              // len is at least 1 in DATA, so len-1 cannot wrap.
              if (word_cnt == len - 16'd1) state <= FINISH;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        FINISH:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Testbench for code_loader (code_size=12, max_code_line=100).
// Expected strobes come from a model of the image format: the line count is
// bytes 0..1, and word i is (byte[2+2i] | byte[3+2i]<<8) masked to 12 bits.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_write;
  logic [31:0] write_line;
  logic [11:0] write_data;
  logic        busy;
  logic        done;
  logic        error;

  code_loader #(.code_size(12), .max_code_line(100)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .is_write(is_write), .write_line(write_line), .write_data(write_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] line;
    logic [11:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check any strobe against the next expected write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (is_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(is_write), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_line", write_line, e.line);
        check("write_data", 32'(write_data), 32'(e.data));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = $urandom_range(max_gap, 0);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_expected();
    int len;
    len = int'(stim[0]) + 256 * int'(stim[1]);
    if (len >= 1 && len <= 101) begin
      for (int i = 0; i < len; i++) begin
        wr_t e;
        e.line = 32'(i);
        e.data = 12'((int'(stim[2+2*i]) + 256 * int'(stim[3+2*i])) % 4096);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_random(input int len);
    stim.delete();
    stim.push_back(8'(len % 256));
    stim.push_back(8'(len / 256));
    for (int i = 0; i < 2 * len; i++) stim.push_back(8'($urandom));
  endtask

  task automatic set_basic();
    stim = '{8'h03, 8'h00, 8'h34, 8'hF2, 8'h78, 8'h05, 8'hBC, 8'h0A};
  endtask

  task automatic run_load(input int max_gap, input bit mid_start);
    int len;
    len = int'(stim[0]) + 256 * int'(stim[1]);
    push_expected();
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
    send_byte(stim[0], max_gap);
    send_byte(stim[1], max_gap);
    if (len == 0) begin
      check("empty_done", 32'(done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_error", 32'(error), 32'd0);
    end else if (len > 101) begin
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_ready", 32'(in_ready), 32'd0);
      check("ovf_busy", 32'(busy), 32'd0);
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      check("ovf_error_hold", 32'(error), 32'd1);
      check("ovf_done", 32'(done), 32'd0);
    end else begin
      for (int k = 2; k < 2 + 2 * len; k++) begin
        send_byte(stim[k], max_gap);
        if (mid_start && k == 2) begin
          start = 1'b1;
          tick();
          start = 1'b0;
          check("mid_start_busy", 32'(busy), 32'd1);
        end
      end
      check("final_strobe", 32'(is_write), 32'd1);
      check("done_early", 32'(done), 32'd0);
      tick();
      check("done", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("strobe_width", 32'(is_write), 32'd0);
      check("pending_strobes", 32'(exp_q.size()), 32'd0);
    end
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_is_write"}, 32'(is_write), 32'd0);
    check({tag, "_write_line"}, write_line, 32'd0);
    check({tag, "_write_data"}, 32'(write_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd0);

    set_basic();
    run_load(0, 1'b0);
    $display("basic load: checks=%0d failures=%0d", n_checks, n_fail);

    stim = '{8'h00, 8'h00};
    run_load(0, 1'b0);
    $display("empty image: checks=%0d failures=%0d", n_checks, n_fail);

    stim = '{8'h66, 8'h00};
    run_load(0, 1'b0);
    stim = '{8'h00, 8'h01};
    run_load(0, 1'b0);
    $display("overflow: checks=%0d failures=%0d", n_checks, n_fail);

    fill_random(101);
    run_load(0, 1'b0);
    $display("full capacity: checks=%0d failures=%0d", n_checks, n_fail);

    set_basic();
    run_load(5, 1'b0);
    $display("throttled: checks=%0d failures=%0d", n_checks, n_fail);

    // Reset after the fifth byte: word 0 has been written, and word 1 is
    // half assembled.
    set_basic();
    push_expected();
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(stim[k], 0);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();
    check("post_reset_busy", 32'(busy), 32'd0);
    $display("reset mid-load: checks=%0d failures=%0d", n_checks, n_fail);

    set_basic();
    run_load(2, 1'b1);
    $display("reload with ignored start: checks=%0d failures=%0d", n_checks, n_fail);

    stim = '{8'h01, 8'h00, 8'hFF, 8'h0F};
    run_load(0, 1'b0);
    $display("reload from done: checks=%0d failures=%0d", n_checks, n_fail);

    for (int r = 0; r < 5; r++) begin
      fill_random(int'($urandom_range(6, 1)));
      run_load(3, 1'b0);
      $display("random load %0d: checks=%0d failures=%0d", r, n_checks, n_fail);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
